uart_cmd_seq: RTL and testbench

Sequencer sitting directly behind uart_rcv. Consumes received bytes via the rx_rdy/clr_rx_rdy handshake and assembles 3-byte command frames (opcode, data high, data low) into one 24-bit command word for the command dispatcher. Enforces an inter-byte timeout so a lost byte cannot misalign later frames. Flags timeout and unread-command overrun.

---
 rtl/uart_cmd_seq.sv | 124 ++++++++++++
 tb/tb_uart_cmd_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_seq.sv
// Assembles 3-byte UART command frames (opcode, data hi, data lo) into a 24-bit
// command word, with inter-byte timeout and unread-command overrun detection.
module uart_cmd_seq #(
  parameter int unsigned TIMEOUT = 52080,
  parameter int unsigned CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        frame_err,
  output logic        overrun
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT1 = 2'd1,
    WAIT2 = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      hold_q, hold_d;
  logic [23:0]      cmd_q, cmd_d;
  logic             cmd_rdy_q, cmd_rdy_d;
  logic             clr_rx_q, clr_rx_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             capture_c;
  logic             expired_c;

  // The acknowledge cycle masks rx_rdy, which uart_rcv still shows high then.
  assign capture_c = rx_rdy & ~clr_rx_q;
  assign expired_c = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      cmd_q       <= '0;
      cmd_rdy_q   <= 1'b0;
      clr_rx_q    <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
      clr_rx_q    <= clr_rx_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    cmd_d       = cmd_q;
    cmd_rdy_d   = cmd_rdy_q & ~clr_cmd_rdy;
    clr_rx_d    = capture_c;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (capture_c) begin
          hold_d[15:8] = rx_data;
          state_d      = WAIT1;
        end
      end
      WAIT1: begin
        if (capture_c) begin
          hold_d[7:0] = rx_data;
          cnt_d       = '0;
          state_d     = WAIT2;
        end else if (expired_c) begin
          frame_err_d = 1'b1;
          cnt_d       = '0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT2: begin
        if (capture_c) begin
          // Set beats a same-cycle clear; an unread frame is overwritten.
          cmd_d     = {hold_q, rx_data};
          cmd_rdy_d = 1'b1;
          overrun_d = cmd_rdy_q & ~clr_cmd_rdy;
          cnt_d     = '0;
          state_d   = IDLE;
        end else if (expired_c) begin
          frame_err_d = 1'b1;
          cnt_d       = '0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign clr_rx_rdy = clr_rx_q;
  assign cmd        = cmd_q;
  assign cmd_rdy    = cmd_rdy_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_cmd_seq.sv
// Directed bench for uart_cmd_seq with a small uart_rcv handshake model and a
// shortened timeout so boundary cases stay cheap to simulate.
module tb_uart_cmd_seq;

  localparam int unsigned T = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        clr_rx_rdy;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        frame_err;
  logic        overrun;

  int n_tests = 0;
  int n_fail  = 0;
  int n_clr   = 0;
  int n_fe    = 0;
  int n_ovr   = 0;
  int base_clr, base_fe, base_ovr;

  uart_cmd_seq #(.TIMEOUT(T), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .clr_rx_rdy (clr_rx_rdy),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (clr_rx_rdy) n_clr++;
    if (frame_err)  n_fe++;
    if (overrun)    n_ovr++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
  endtask

  // uart_rcv model: raise rx_rdy, keep it up through the ack cycle, drop it after.
  task automatic send_byte(input logic [7:0] b, input logic ack);
    rx_data     = b;
    rx_rdy      = 1'b1;
    clr_cmd_rdy = ack;
    @(posedge clk);
    #1;
    clr_cmd_rdy = 1'b0;
    chk("clr_rx_lat", 32'(clr_rx_rdy), 32'd1);
    @(posedge clk);
    #1;
    rx_rdy = 1'b0;
  endtask

  task automatic ack_cmd();
    clr_cmd_rdy = 1'b1;
    idle(1);
    clr_cmd_rdy = 1'b0;
  endtask

  initial begin
    idle(2);
    chk("rst_cmd", 32'(cmd), 32'h0);
    chk("rst_outs", {28'h0, clr_rx_rdy, cmd_rdy, frame_err, overrun}, 32'h0);
    rst = 1'b0;
    idle(1);

    // 1: nominal frame
    base_clr = n_clr;
    send_byte(8'hA5, 1'b0);
    chk("t1_rdy_early", 32'(cmd_rdy), 32'd0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    chk("t1_cmd", 32'(cmd), 32'hA51234);
    chk("t1_rdy", 32'(cmd_rdy), 32'd1);
    chk("t1_clr_cnt", 32'(n_clr - base_clr), 32'd3);
    ack_cmd();
    chk("t1_rdy_clr", 32'(cmd_rdy), 32'd0);
    chk("t1_cmd_hold", 32'(cmd), 32'hA51234);

    // 2: rx_rdy held across the ack cycle must capture once
    do_reset();
    base_clr = n_clr;
    send_byte(8'h55, 1'b0);
    idle(2);
    chk("t2_clr_cnt", 32'(n_clr - base_clr), 32'd1);
    send_byte(8'h66, 1'b0);
    chk("t2_rdy_mid", 32'(cmd_rdy), 32'd0);
    send_byte(8'h77, 1'b0);
    chk("t2_cmd", 32'(cmd), 32'h556677);
    chk("t2_rdy", 32'(cmd_rdy), 32'd1);

    // 3: timeout discards a partial frame and realigns
    do_reset();
    base_fe = n_fe;
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    idle(T + 2);
    chk("t3_fe_cnt", 32'(n_fe - base_fe), 32'd1);
    chk("t3_rdy", 32'(cmd_rdy), 32'd0);
    chk("t3_cmd", 32'(cmd), 32'h0);
    send_byte(8'hC3, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    chk("t3_cmd_realign", 32'(cmd), 32'hC300FF);
    chk("t3_fe_cnt2", 32'(n_fe - base_fe), 32'd1);

    // 4: byte on the last allowed cycle vs one cycle late
    do_reset();
    base_fe = n_fe;
    send_byte(8'hAA, 1'b0);
    idle(T - 2);
    send_byte(8'hBB, 1'b0);
    chk("t4_ontime_fe", 32'(n_fe - base_fe), 32'd0);
    send_byte(8'hCC, 1'b0);
    chk("t4_ontime_cmd", 32'(cmd), 32'hAABBCC);
    ack_cmd();
    send_byte(8'hDD, 1'b0);
    idle(T - 1);
    chk("t4_late_fe_pulse", 32'(frame_err), 32'd1);
    send_byte(8'h11, 1'b0);
    chk("t4_late_fe_cnt", 32'(n_fe - base_fe), 32'd1);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    chk("t4_late_cmd", 32'(cmd), 32'h112233);
    chk("t4_late_rdy", 32'(cmd_rdy), 32'd1);

    // 5: overrun, then set-wins against a same-cycle clear
    do_reset();
    base_ovr = n_ovr;
    send_byte(8'h11, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h11, 1'b0);
    chk("t5_first_cmd", 32'(cmd), 32'h111111);
    chk("t5_no_ovr_yet", 32'(n_ovr - base_ovr), 32'd0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h22, 1'b0);
    chk("t5_ovr_cnt", 32'(n_ovr - base_ovr), 32'd1);
    chk("t5_cmd", 32'(cmd), 32'h222222);
    chk("t5_rdy", 32'(cmd_rdy), 32'd1);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b1);
    chk("t5_setwins_rdy", 32'(cmd_rdy), 32'd1);
    chk("t5_setwins_cmd", 32'(cmd), 32'h334455);
    chk("t5_setwins_ovr", 32'(n_ovr - base_ovr), 32'd1);

    // 6: reset mid-frame
    do_reset();
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    rst = 1'b1;
    #1;
    chk("t6_rst_cmd", 32'(cmd), 32'h0);
    chk("t6_rst_outs", {28'h0, clr_rx_rdy, cmd_rdy, frame_err, overrun}, 32'h0);
    idle(1);
    rst = 1'b0;
    idle(1);
    send_byte(8'h0A, 1'b0);
    send_byte(8'h0B, 1'b0);
    send_byte(8'h0C, 1'b0);
    chk("t6_cmd", 32'(cmd), 32'h0A0B0C);
    chk("t6_rdy", 32'(cmd_rdy), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
